// File: rtl/grf_pkg.sv
// Shared widths and constants for the register-file write-port arbiter.
// Also holds the grant encoding used by the top-level mux.
package grf_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MDU  = 2'd2
    } grant_e;

    function automatic logic is_real_reg(input logic [REG_W-1:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard for in-flight MDU operations.
// Tracks busy registers, flags WAW issues, and bypasses same-cycle issues to decode.
module grf_scoreboard
    import grf_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue,
    input  logic [REG_W-1:0] issue_reg,
    input  logic             clr,
    input  logic [REG_W-1:0] clr_reg,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             busy_rs,
    output logic             busy_rt,
    output logic             err_waw
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // The set is applied after the clear so that a same-cycle issue wins.
    always_comb begin
        busy_nxt = busy;
        if (clr) begin
            busy_nxt[clr_reg] = 1'b0;
        end
        if (issue) begin
            busy_nxt[issue_reg] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= '0;
            err_waw <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (issue && busy[issue_reg]) begin
                err_waw <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_rs = busy[rs] | (issue && issue_reg == rs && is_real_reg(rs));
        busy_rt = busy[rt] | (issue && issue_reg == rt && is_real_reg(rt));
    end

endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the register file write port between pipeline writeback and the MDU.
// The pipe normally wins; the MDU is force-granted after STARVE_LIMIT denied cycles.
module grf_wport_arbiter
    import grf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pipe_we,
    input  logic [REG_W-1:0]  pipe_wreg,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    input  logic              mdu_valid,
    input  logic [REG_W-1:0]  mdu_wreg,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    input  logic              mdu_issue,
    input  logic [REG_W-1:0]  mdu_issue_reg,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              grf_we,
    output logic [REG_W-1:0]  grf_wreg,
    output logic [DATA_W-1:0] grf_wdata,
    output logic              err_waw
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic   [3:0] starve_cnt;
    logic         pipe_req;
    logic         mdu_port_req;
    logic         force_mdu;
    grant_e       grant;

    // Writes to register zero never need the port, so they never compete for it.
    always_comb begin
        pipe_req     = pipe_we && is_real_reg(pipe_wreg);
        mdu_port_req = mdu_valid && is_real_reg(mdu_wreg);
        force_mdu    = starve_cnt >= LIMIT;
        grant        = GNT_NONE;
        if (!reset_n) begin
            grant = GNT_NONE;
        end else if (pipe_req && mdu_port_req) begin
            grant = force_mdu ? GNT_MDU : GNT_PIPE;
        end else if (pipe_req) begin
            grant = GNT_PIPE;
        end else if (mdu_port_req) begin
            grant = GNT_MDU;
        end
    end

    always_comb begin
        pipe_stall = (grant == GNT_MDU) && pipe_req;
        mdu_ready  = reset_n && mdu_valid && (!is_real_reg(mdu_wreg) || grant == GNT_MDU);
        grf_we     = 1'b0;
        grf_wreg   = REG_ZERO;
        grf_wdata  = '0;
        case (grant)
            GNT_PIPE: begin
                grf_we    = 1'b1;
                grf_wreg  = pipe_wreg;
                grf_wdata = pipe_wdata;
            end
            GNT_MDU: begin
                grf_we    = 1'b1;
                grf_wreg  = mdu_wreg;
                grf_wdata = mdu_wdata;
            end
            default: begin
                grf_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (!mdu_valid || mdu_ready) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    grf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .issue     (mdu_issue),
        .issue_reg (mdu_issue_reg),
        .clr       (mdu_ready),
        .clr_reg   (mdu_wreg),
        .rs        (rs),
        .rt        (rt),
        .busy_rs   (busy_rs),
        .busy_rt   (busy_rt),
        .err_waw   (err_waw)
    );

endmodule
